spram2_arb: RTL
===============

Name: spram2_arb

Overview:
- Two-requester arbiter and sequencer for the shared dual-address synchronous RAM (spram2 instance) used as the intra-prediction / deblocking neighbour buffer.
- Grants one access per cycle using round-robin, with optional locked bursts bounded by a maximum length.
- Drives the RAM control, address and data pins, and returns tagged read data one cycle after the grant.

Parameters:
- AW, 8, RAM address width.
- DW, 32, RAM data width.
- MAX_BURST, 16, maximum consecutive granted cycles a locking requester may hold (>=1).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- req0 / req1  in  1  access request, requester 0 / 1
- lock0 / lock1  in  1  hold ownership after this access (burst)
- we0 / we1  in  1  1 = write, 0 = read
- addr0 / addr1  in  AW  access address
- wdata0 / wdata1  in  DW  write data
- gnt0 / gnt1  out  1  access accepted this cycle (combinational from registered state and req)
- rdata  out  DW  read data, valid only with rvalid0/1
- rvalid0 / rvalid1  out  1  registered pulse, read data for requester 0 / 1
- ram_ce, ram_we, ram_oe, ram_valid  out  1  RAM controls
- ram_addr_w, ram_addr_r  out  AW  RAM addresses
- ram_data  out  DW  RAM write data
- ram_q  in  DW  RAM output data

Behaviour:
- Reset (async): state = IDLE, rr_ptr = 0 (requester 0 favoured), burst_cnt = 0, rvalid0/1 = 0. gnt0/1 = 0 while rst is high.
- FSM states: IDLE, OWN0, OWN1.
  - In IDLE, the winner is the requester with req set. If both request, the winner is the one selected by rr_ptr.
  - In OWNx, only requester x can be granted, and gnt for the other requester is 0.
- Transitions on a granted cycle:
  - If lock of the winner = 1 and burst_cnt + 1 < MAX_BURST: go to OWNwinner and increment burst_cnt.
  - Otherwise: go to IDLE, clear burst_cnt, set rr_ptr = the other requester.
- In OWNx with reqx = 0: no grant. Return to IDLE, clear burst_cnt, set rr_ptr = the other requester. This is a one-cycle release bubble.
- Granted cycle RAM drive:
  - ram_ce = 1, ram_valid = 1, ram_we = we of winner, ram_oe = ~we of winner.
  - ram_addr_w = ram_addr_r = addr of winner; ram_data = wdata of winner.
- Non-granted cycle RAM drive: ram_ce = 0, ram_we = 0, ram_valid = 0; addresses and data hold the requester 0 values (don't care).
- Read latency: a read granted in cycle N gives rvalid<winner> = 1 in cycle N+1 and rdata = ram_q in N+1. rvalid is a single-cycle pulse per granted read.
- Back-to-back reads produce one rvalid per cycle. A write gives no rvalid.
- Read-after-write to the same address in consecutive granted cycles returns the new data, because RAM read data is taken from the memory array after the write edge.
- A write and a read in the same cycle are impossible, since only one access is granted per cycle.
- Requester contract: a requester keeps req, we, addr and wdata stable until it sees gnt. Deasserting req before gnt is allowed (request withdrawn).
- Reset mid-burst: state returns to IDLE immediately. Any pending rvalid is dropped.
- MAX_BURST = 1 disables locking.

Decomposition:
- Shared package holds the state encoding (IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2) and the requester index constants REQ0 = 1'b0, REQ1 = 1'b1.
- One sub-module, spram2_rr_pick: a combinational 2-way round-robin picker (req0, req1, rr_ptr, state) -> (gnt0, gnt1).
- Top level holds the FSM, burst counter, RAM muxing and the rvalid pipeline register.

Test Plan:
- Reset release, req0 = 1, we0 = 1, addr0 = 8'h05, wdata0 = 32'hDEADBEEF -> gnt0 = 1 the same cycle, ram_ce = 1, ram_we = 1, ram_addr_w = 8'h05. Then req0 read of 8'h05 -> rvalid0 = 1 next cycle, rdata = 32'hDEADBEEF.
- req0 and req1 both asserted continuously, lock = 0, reads -> grants alternate 0, 1, 0, 1 starting with 0. rvalid0 and rvalid1 alternate, each one cycle late.
- req0 with lock0 = 1 for 20 cycles and req1 held, MAX_BURST = 16 -> gnt0 for 16 consecutive cycles, then gnt1 for 1 cycle, then requester 0 resumes.
- Requester 0 in OWN0 drops req0 for one cycle while req1 is high -> no grant that cycle. The next cycle gives gnt1 = 1.
- Write 8'h10 = 32'h1 then immediately read 8'h10 from requester 1 -> rvalid1 = 1 with rdata = 32'h1.
- Assert rst during a locked read burst -> gnt0/1 = 0 and rvalid = 0 immediately. After release, requester 0 wins a tie.

Source files
------------

// File: rtl/spram2_arb_pkg.sv
// Shared types and constants for the spram2 two-requester arbiter.
// Holds the FSM state encoding and requester index constants.
package spram2_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  function automatic logic other_req(input logic idx);
    return ~idx;
  endfunction

endpackage

// File: rtl/spram2_arb_if.sv
// Requester and RAM-side bundle of the spram2 arbiter.
// The slave modport is the arbiter; the master modport is requesters plus the RAM.
interface spram2_arb_if #(
  parameter int AW = 8,
  parameter int DW = 32
);
  logic          req0, req1;
  logic          lock0, lock1;
  logic          we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1;
  logic [DW-1:0] rdata;
  logic          rvalid0, rvalid1;
  logic          ram_ce, ram_we, ram_oe, ram_valid;
  logic [AW-1:0] ram_addr_w, ram_addr_r;
  logic [DW-1:0] ram_data;
  logic [DW-1:0] ram_q;

  modport slave (
    input  req0, req1, lock0, lock1, we0, we1, addr0, addr1, wdata0, wdata1, ram_q,
    output gnt0, gnt1, rdata, rvalid0, rvalid1,
           ram_ce, ram_we, ram_oe, ram_valid, ram_addr_w, ram_addr_r, ram_data
  );

  modport master (
    output req0, req1, lock0, lock1, we0, we1, addr0, addr1, wdata0, wdata1, ram_q,
    input  gnt0, gnt1, rdata, rvalid0, rvalid1,
           ram_ce, ram_we, ram_oe, ram_valid, ram_addr_w, ram_addr_r, ram_data
  );
endinterface

// File: rtl/spram2_rr_pick.sv
// Combinational 2-way round-robin picker; an owning requester excludes the other.
module spram2_rr_pick
  import spram2_arb_pkg::*;
(
  input  logic   i_req0,
  input  logic   i_req1,
  input  logic   i_rr_ptr,
  input  state_t i_state,
  output logic   o_gnt0,
  output logic   o_gnt1
);

  // Select the winner for this cycle from state, requests and pointer.
  always_comb begin
    o_gnt0 = 1'b0;
    o_gnt1 = 1'b0;
    case (i_state)
      IDLE: begin
        if (i_req0 && i_req1) begin
          o_gnt0 = (i_rr_ptr == REQ0);
          o_gnt1 = (i_rr_ptr == REQ1);
        end else begin
          o_gnt0 = i_req0;
          o_gnt1 = i_req1;
        end
      end
      OWN0:    o_gnt0 = i_req0;
      OWN1:    o_gnt1 = i_req1;
      default: begin
        o_gnt0 = 1'b0;
        o_gnt1 = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/spram2_arb.sv
// Arbiter/sequencer for the shared spram2 neighbour buffer: one access per cycle,
// round-robin with bounded locked bursts, tagged read data one cycle after grant.
module spram2_arb
  import spram2_arb_pkg::*;
#(
  parameter int AW        = 8,
  parameter int DW        = 32,
  parameter int MAX_BURST = 16
) (
  input  logic          clk,
  input  logic          rst,
  spram2_arb_if.slave   bus
);

  localparam int CW = $clog2(MAX_BURST + 1);

  state_t        r_state;
  logic          r_rr_ptr;
  logic [CW-1:0] r_burst_cnt;
  logic          r_rvalid0, r_rvalid1;

  logic          w_pick0, w_pick1;
  logic          w_gnt0, w_gnt1, w_any, w_win;
  logic          w_we, w_lock;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_data;
  logic [CW-1:0] w_cnt_inc;

  spram2_rr_pick u_pick (
    .i_req0   (bus.req0),
    .i_req1   (bus.req1),
    .i_rr_ptr (r_rr_ptr),
    .i_state  (r_state),
    .o_gnt0   (w_pick0),
    .o_gnt1   (w_pick1)
  );

  // Grants are forced low for the whole time reset is asserted.
  assign w_gnt0    = w_pick0 & ~rst;
  assign w_gnt1    = w_pick1 & ~rst;
  assign w_any     = w_gnt0 | w_gnt1;
  assign w_win     = w_gnt1 ? REQ1 : REQ0;
  assign w_cnt_inc = r_burst_cnt + CW'(1'b1);

  // Route the winner's request fields to the RAM; requester 0 when idle.
  always_comb begin
    w_we   = 1'b0;
    w_lock = 1'b0;
    w_addr = bus.addr0;
    w_data = bus.wdata0;
    if (w_win == REQ1) begin
      w_we   = bus.we1;
      w_lock = bus.lock1;
      w_addr = bus.addr1;
      w_data = bus.wdata1;
    end else begin
      w_we   = bus.we0;
      w_lock = bus.lock0;
      w_addr = bus.addr0;
      w_data = bus.wdata0;
    end
  end

  // Ownership FSM, burst counter, round-robin pointer and read-valid pipeline.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_rr_ptr    <= REQ0;
      r_burst_cnt <= {CW{1'b0}};
      r_rvalid0   <= 1'b0;
      r_rvalid1   <= 1'b0;
    end else begin
      r_rvalid0 <= w_gnt0 & ~bus.we0;
      r_rvalid1 <= w_gnt1 & ~bus.we1;
      if (w_any) begin
        if (w_lock && (w_cnt_inc < CW'(MAX_BURST))) begin
          r_state     <= (w_win == REQ1) ? OWN1 : OWN0;
          r_burst_cnt <= w_cnt_inc;
        end else begin
          r_state     <= IDLE;
          r_burst_cnt <= {CW{1'b0}};
          r_rr_ptr    <= other_req(w_win);
        end
      end else if (r_state != IDLE) begin
        // Owner released without a request: one-cycle bubble, then hand over.
        r_state     <= IDLE;
        r_burst_cnt <= {CW{1'b0}};
        r_rr_ptr    <= other_req((r_state == OWN1) ? REQ1 : REQ0);
      end else begin
        r_state <= r_state;
      end
    end
  end

  assign bus.gnt0       = w_gnt0;
  assign bus.gnt1       = w_gnt1;
  assign bus.rdata      = bus.ram_q;
  assign bus.rvalid0    = r_rvalid0;
  assign bus.rvalid1    = r_rvalid1;
  assign bus.ram_ce     = w_any;
  assign bus.ram_valid  = w_any;
  assign bus.ram_we     = w_any & w_we;
  assign bus.ram_oe     = w_any & ~w_we;
  assign bus.ram_addr_w = w_addr;
  assign bus.ram_addr_r = w_addr;
  assign bus.ram_data   = w_data;

endmodule
